// File: rtl/vmem_pkg.sv
// Shared definitions for the vmem display scan-out path: geometry defaults,
// FSM state encoding and the 3-bit colour to RGB565 expansion.
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 16
`endif

package vmem_pkg;

  localparam int unsigned H_PIX_DEF = 240;
  localparam int unsigned V_PIX_DEF = 240;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned FIFO_W = PIX_W + 2;

  // Each colour bit saturates its whole RGB565 field.
  function automatic logic [15:0] rgb565(input logic [2:0] d);
    return {{5{d[2]}}, {6{d[1]}}, {5{d[0]}}};
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry register FIFO with same-cycle push/pop; head is read combinationally.
module pix_fifo2 #(
  parameter int unsigned W = 18
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [0:1];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/vmem_scanout.sv
// Scans vmem in raster order and streams RGB565 pixels with sof/eol markers
// over a valid/ready handshake, one read in flight ahead of a 2-entry FIFO.
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 16
`endif

module vmem_scanout
  import vmem_pkg::*;
#(
  parameter int unsigned H_PIX = H_PIX_DEF,
  parameter int unsigned V_PIX = V_PIX_DEF,
  parameter int unsigned ADDRW = `VMEM_ADDRW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [ADDRW-1:0] vmem_raddr_o,
  input  logic [2:0]       vmem_rdata_i,
  output logic             pix_valid_o,
  input  logic             pix_ready_i,
  output logic [15:0]      pix_data_o,
  output logic             pix_sof_o,
  output logic             pix_eol_o,
  output logic             frame_done_o,
  output logic             busy_o
);

  localparam int unsigned XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int unsigned YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIX - 1);

  logic [1:0]        state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDRW-1:0]  addr_q;
  logic              inflight_q;
  logic              pend_sof_q;
  logic              pend_eol_q;
  logic              done_q;

  logic              issue;
  logic              pop;
  logic              last_pop;
  logic              at_last;
  logic [2:0]        occ;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;

  assign pop     = ~fifo_empty & pix_ready_i;
  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

  // Occupancy credits the pop happening this cycle so that a streaming sink
  // sees one pixel per cycle; the FIFO still never exceeds two entries.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == ST_SCAN) && (occ < 3'd2);

  // The final pixel is the one leaving an otherwise empty pipeline in DRAIN.
  assign last_pop = (state_q == ST_DRAIN) && pop && (fifo_count == 2'd1) && !inflight_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (issue) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
            addr_q <= addr_q + ADDRW'(1);
            if (at_last) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            state_q <= en_i ? ST_SCAN : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      pend_sof_q <= 1'b0;
      pend_eol_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= last_pop;
      if (issue) begin
        pend_sof_q <= (x_q == '0) && (y_q == '0);
        pend_eol_q <= (x_q == X_LAST);
      end
    end
  end

  assign fifo_din  = {pend_sof_q, pend_eol_q, rgb565(vmem_rdata_i)};
  assign fifo_push = inflight_q & (~fifo_full | pop);

  pix_fifo2 #(
    .W(FIFO_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign vmem_raddr_o = issue ? addr_q : '0;
  assign pix_valid_o  = ~fifo_empty;
  assign pix_data_o   = fifo_empty ? '0 : fifo_dout[PIX_W-1:0];
  assign pix_sof_o    = ~fifo_empty & fifo_dout[FIFO_W-1];
  assign pix_eol_o    = ~fifo_empty & fifo_dout[FIFO_W-2];
  assign frame_done_o = done_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vmem_scanout.sv
// Directed/randomised bench for vmem_scanout on a 4x4 frame with a behavioural vmem.
module tb_vmem_scanout;

  localparam int H    = 4;
  localparam int V    = 4;
  localparam int NPIX = H * V;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] raddr;
  logic [2:0]    rdata;
  logic          valid, sof, eol, done, busy;
  logic [15:0]   data;
  logic [2:0]    vmem [0:255];

  int n_checks = 0;
  int n_err    = 0;

  int   idx = 0, n_acc = 0, n_done = 0, n_sof = 0;
  int   step_no = 0, first_acc_step = 0, last_acc_step = 0;
  bit   done_exp = 1'b0, hold_v = 1'b0;
  logic [17:0] hold_pix;
  logic [15:0] first_data;

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= vmem[raddr];

  vmem_scanout #(
    .H_PIX(H),
    .V_PIX(V),
    .ADDRW(AW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .vmem_raddr_o (raddr),
    .vmem_rdata_i (rdata),
    .pix_valid_o  (valid),
    .pix_ready_i  (ready),
    .pix_data_o   (data),
    .pix_sof_o    (sof),
    .pix_eol_o    (eol),
    .frame_done_o (done),
    .busy_o       (busy)
  );

  function automatic logic [15:0] ref_rgb(input logic [2:0] d);
    return (d[2] ? 16'hF800 : 16'h0000) | (d[1] ? 16'h07E0 : 16'h0000) | (d[0] ? 16'h001F : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive ready at the falling edge, sample shortly after, and
  // score any handshake that the next rising edge will complete.
  task automatic step(input bit rdy);
    @(negedge clk);
    ready = rdy;
    #1;
    step_no++;
    chk("frame_done", done, done_exp);
    if (done) n_done++;
    done_exp = 1'b0;
    if (hold_v) begin
      chk("hold_valid", valid, 1);
      chk("hold_pix", {sof, eol, data}, hold_pix);
    end
    chk("raddr_range", raddr <= AW'(NPIX - 1), 1);
    if (valid && ready) begin
      chk("pix_data", data, ref_rgb(vmem[idx]));
      chk("pix_sof", sof, idx == 0);
      chk("pix_eol", eol, (idx % H) == H - 1);
      if (sof) n_sof++;
      if (n_acc == 0) begin
        first_acc_step = step_no;
        first_data     = data;
      end
      last_acc_step = step_no;
      n_acc++;
      if (idx == NPIX - 1) begin
        done_exp = 1'b1;
        idx      = 0;
      end else begin
        idx++;
      end
    end
    hold_v   = valid && !ready;
    hold_pix = {sof, eol, data};
  endtask

  task automatic run_idle(input int bound, input bit rnd);
    for (int i = 0; i < bound; i++) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (!busy && !valid) break;
    end
    chk("idle_timeout", {busy, valid}, 0);
  endtask

  task automatic run_until_acc(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (n_acc >= target) break;
      step(1'($urandom_range(0, 1)));
    end
    chk("acc_timeout", n_acc >= target, 1);
  endtask

  task automatic clr();
    n_acc  = 0;
    n_done = 0;
    n_sof  = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_sof"}, sof, 0);
    chk({tag, "_eol"}, eol, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_raddr"}, raddr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) vmem[i] = 3'(i % 8);

    // Reset state with enable and ready already asserted
    en = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single frame, sink always ready: order, markers, latency, throughput
    clr();
    en = 1'b1;
    step(1'b1);
    chk("busy_start", busy, 1);
    chk("lat_s1", valid, 0);
    en = 1'b0;
    step(1'b1);
    chk("lat_s2", valid, 0);
    chk("raddr_s2", raddr, 1);
    step(1'b1);
    chk("lat_s3", valid, 1);
    run_idle(60, 1'b0);
    chk("a_count", n_acc, NPIX);
    chk("a_done", n_done, 1);
    chk("a_sof", n_sof, 1);
    chk("a_thru", last_acc_step - first_acc_step, NPIX - 1);

    // Random contents, random backpressure, en dropped at pixel 5
    for (int i = 0; i < 256; i++) vmem[i] = 3'($urandom);
    clr();
    en = 1'b1;
    run_until_acc(5, 200);
    en = 1'b0;
    run_idle(300, 1'b1);
    chk("b_count", n_acc, NPIX);
    chk("b_done", n_done, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("b_idle_valid", valid, 0);
      chk("b_idle_busy", busy, 0);
    end

    // Three back-to-back frames with en held high
    for (int i = 0; i < 256; i++) vmem[i] = 3'($urandom);
    clr();
    en = 1'b1;
    run_until_acc(2 * NPIX + 1, 600);
    en = 1'b0;
    run_idle(300, 1'b1);
    chk("c_count", n_acc, 3 * NPIX);
    chk("c_done", n_done, 3);
    chk("c_sof", n_sof, 3);

    // Reset mid-frame after pixel 9, then a clean frame from address 0
    for (int i = 0; i < 256; i++) vmem[i] = 3'(i % 8);
    clr();
    en = 1'b1;
    run_until_acc(9, 200);
    ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idx = 0;
    hold_v = 1'b0;
    done_exp = 1'b0;
    clr();
    step(1'b1);
    en = 1'b0;
    step(1'b1);
    chk("d_raddr_s2", raddr, 1);
    step(1'b1);
    chk("d_first_sof", sof & valid, 1);
    run_idle(60, 1'b0);
    chk("d_count", n_acc, NPIX);
    chk("d_done", n_done, 1);
    chk("d_first_data", first_data, ref_rgb(3'd0));

    // Colour mapping of 3'b101
    for (int i = 0; i < 256; i++) vmem[i] = 3'b101;
    clr();
    en = 1'b1;
    step(1'b1);
    en = 1'b0;
    run_idle(60, 1'b0);
    chk("e_rgb_101", first_data, 16'hF81F);
    chk("e_count", n_acc, NPIX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
